// File: rtl/bridge_pkg.sv
// Shared constants and types for the CPU-to-device bridge: address map
// defaults, control register offsets and the request FSM encoding.
package bridge_pkg;

    localparam logic [31:0] BASE_DEFAULT     = 32'h0000_7F00;
    localparam logic [31:0] CTL_BASE_DEFAULT = 32'h0000_7FF0;
    localparam logic [31:0] SLOT_STRIDE      = 32'h0000_0010;
    localparam logic [31:0] SLOT_LAST        = 32'h0000_000C;
    localparam logic [31:0] PEND_OFS         = 32'h0000_0000;
    localparam logic [31:0] MASK_OFS         = 32'h0000_0004;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    function automatic logic [31:0] slot_base(input logic [31:0] base, input int idx);
        return base + SLOT_STRIDE * 32'(idx);
    endfunction

endpackage

// File: rtl/irq_ctrl.sv
// Interrupt block: rising-edge detect on dev_irq, sticky PEND (W1C, set
// wins), MASK register and the masked hwint vector.
module irq_ctrl
    import bridge_pkg::*;
#(
    parameter int NSLV = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSLV-1:0] dev_irq,
    input  logic            pend_we,
    input  logic            mask_we,
    input  logic [NSLV-1:0] wd,
    output logic [NSLV-1:0] pend,
    output logic [NSLV-1:0] mask,
    output logic [7:2]      hwint
);

    logic [NSLV-1:0] irq_prev;
    logic            armed;
    logic [NSLV-1:0] irq_rise;
    logic [NSLV-1:0] pend_clr;

    // The first edge after reset only loads history, so a line already high
    // when reset releases is not mistaken for a fresh request.
    assign irq_rise = armed ? (dev_irq & ~irq_prev) : '0;
    assign pend_clr = pend_we ? wd : '0;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev <= '0;
            armed    <= 1'b0;
            pend     <= '0;
            mask     <= '0;
        end else begin
            irq_prev <= dev_irq;
            armed    <= 1'b1;
            pend     <= (pend & ~pend_clr) | irq_rise;
            if (mask_we) begin
                mask <= wd;
            end
        end
    end

    // NOTE: defaulting every combinational output first prevents latches.
    always_comb begin
        hwint = '0;
        for (int i = 0; i < NSLV; i++) begin
            hwint[2+i] = pend[i] & mask[i];
        end
    end

endmodule

// File: rtl/sys_bridge.sv
// CPU-to-device bridge: decodes CPU accesses onto NSLV device slots plus two
// internal interrupt registers, answering each request one cycle later.
module sys_bridge
    import bridge_pkg::*;
#(
    parameter int          NSLV     = 4,
    parameter logic [31:0] BASE     = BASE_DEFAULT,
    parameter logic [31:0] CTL_BASE = CTL_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        praddr,
    input  logic [31:0]        prwd,
    input  logic               wen,
    input  logic               ren,
    output logic [31:0]        prrd,
    output logic               pr_ready,
    output logic               pr_err,
    output logic [1:0]         dev_addr,
    output logic [31:0]        dev_wd,
    output logic [NSLV-1:0]    dev_we,
    input  logic [NSLV*32-1:0] dev_rd,
    input  logic [NSLV-1:0]    dev_irq,
    output logic [7:2]         hwint
);

    state_t          state, state_n;
    logic [NSLV-1:0] hit;
    logic [31:0]     rd_sel;
    logic [31:0]     rdata;
    logic            is_pend, is_mask, mapped, err;
    logic            accept, pend_we, mask_we;
    logic [NSLV-1:0] pend, mask;

    assign dev_addr = praddr[3:2];
    assign dev_wd   = prwd;

    always_comb begin
        hit    = '0;
        rd_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (praddr >= slot_base(BASE, i) && praddr <= slot_base(BASE, i) + SLOT_LAST) begin
                hit[i] = 1'b1;
                rd_sel = dev_rd[32*i +: 32];
            end
        end
    end

    assign is_pend = (praddr == CTL_BASE + PEND_OFS);
    assign is_mask = (praddr == CTL_BASE + MASK_OFS);
    assign mapped  = (|hit) | is_pend | is_mask;
    // A simultaneous read and write still performs the write, but flags it.
    assign err     = ~mapped | (wen & ren);

    always_comb begin
        rdata = '0;
        if (is_pend) begin
            rdata[NSLV-1:0] = pend;
        end else if (is_mask) begin
            rdata[NSLV-1:0] = mask;
        end else begin
            rdata = rd_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (wen || ren) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        accept  = (state == IDLE) && (wen || ren);
        dev_we  = (accept && wen) ? hit : '0;
        pend_we = accept && wen && is_pend;
        mask_we = accept && wen && is_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prrd     <= '0;
            pr_ready <= 1'b0;
            pr_err   <= 1'b0;
        end else begin
            pr_ready <= accept;
            if (accept) begin
                pr_err <= err;
                if (err) begin
                    prrd <= '0;
                end else if (ren) begin
                    prrd <= rdata;
                end
            end
        end
    end

    irq_ctrl #(
        .NSLV(NSLV)
    ) u_irq_ctrl (
        .clk     (clk),
        .reset   (reset),
        .dev_irq (dev_irq),
        .pend_we (pend_we),
        .mask_we (mask_we),
        .wd      (prwd[NSLV-1:0]),
        .pend    (pend),
        .mask    (mask),
        .hwint   (hwint)
    );

endmodule

// File: tb/tb_sys_bridge.sv
// Directed bench for sys_bridge (NSLV=4): slot decode, error cases, the
// interrupt registers and reset abort, against hand-computed values.
module tb_sys_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  praddr, prwd;
    logic         wen, ren;
    logic [31:0]  prrd;
    logic         pr_ready, pr_err;
    logic [1:0]   dev_addr;
    logic [31:0]  dev_wd;
    logic [3:0]   dev_we;
    logic [127:0] dev_rd;
    logic [3:0]   dev_irq;
    logic [7:2]   hwint;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sys_bridge #(
        .NSLV     (4),
        .BASE     (32'h0000_7F00),
        .CTL_BASE (32'h0000_7FF0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .praddr   (praddr),
        .prwd     (prwd),
        .wen      (wen),
        .ren      (ren),
        .prrd     (prrd),
        .pr_ready (pr_ready),
        .pr_err   (pr_err),
        .dev_addr (dev_addr),
        .dev_wd   (dev_wd),
        .dev_we   (dev_we),
        .dev_rd   (dev_rd),
        .dev_irq  (dev_irq),
        .hwint    (hwint)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction; the request is held through RESP to show it is ignored.
    task automatic bus(input string tag, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] exp_we, input logic exp_err,
                       input logic chk_rd, input logic [31:0] exp_rd);
        wen = w; ren = r; praddr = a; prwd = d;
        #1;
        check({tag, ".we"}, 32'(dev_we), 32'(exp_we));
        tick();
        check({tag, ".rdy"}, 32'(pr_ready), 32'd1);
        check({tag, ".err"}, 32'(pr_err), 32'(exp_err));
        if (chk_rd) check({tag, ".rd"}, prrd, exp_rd);
        check({tag, ".held_we"}, 32'(dev_we), 32'd0);
        wen = 1'b0; ren = 1'b0;
        tick();
        check({tag, ".rdy_off"}, 32'(pr_ready), 32'd0);
    endtask

    initial begin
        reset = 1'b1; praddr = '0; prwd = '0; wen = 1'b0; ren = 1'b0;
        dev_rd = '0; dev_irq = '0;
        tick(); tick();
        check("rst.prrd", prrd, 32'd0);
        check("rst.rdy", 32'(pr_ready), 32'd0);
        check("rst.err", 32'(pr_err), 32'd0);
        check("rst.hwint", 32'(hwint), 32'd0);
        reset = 1'b0;
        tick();

        // Slot write, then read of slot 2
        wen = 1'b1; praddr = 32'h7F14; prwd = 32'h1234;
        #1;
        check("wr.addr", 32'(dev_addr), 32'd1);
        check("wr.wd", dev_wd, 32'h1234);
        bus("wr", 1'b1, 1'b0, 32'h7F14, 32'h1234, 4'b0010, 1'b0, 1'b0, 32'h0);

        dev_rd[64 +: 32] = 32'hCAFE;
        dev_rd[96 +: 32] = 32'h0033_0033;
        bus("rd2", 1'b0, 1'b1, 32'h7F28, 32'h0, 4'b0000, 1'b0, 1'b1, 32'hCAFE);
        check("rd2.hold", prrd, 32'hCAFE);
        bus("rd3_last", 1'b0, 1'b1, 32'h7F3C, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0033_0033);

        // Error cases
        bus("unmap", 1'b0, 1'b1, 32'h7E00, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0);
        bus("past_slots", 1'b0, 1'b1, 32'h7F40, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0);
        bus("wr_unmap", 1'b1, 1'b0, 32'h7F40, 32'h5, 4'b0000, 1'b1, 1'b1, 32'h0);
        bus("both", 1'b1, 1'b1, 32'h7F00, 32'h77, 4'b0001, 1'b1, 1'b1, 32'h0);

        // Interrupt registers
        bus("mask_wr", 1'b1, 1'b0, 32'h7FF4, 32'h1, 4'b0000, 1'b0, 1'b0, 32'h0);
        bus("mask_rd", 1'b0, 1'b1, 32'h7FF4, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h1);
        dev_irq = 4'b0011;
        tick();
        check("irq.hwint", 32'(hwint), 32'b000001);
        dev_irq = 4'b0000;
        bus("pend_rd", 1'b0, 1'b1, 32'h7FF0, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h3);
        bus("pend_clr", 1'b1, 1'b0, 32'h7FF0, 32'h1, 4'b0000, 1'b0, 1'b0, 32'h0);
        check("clr.hwint", 32'(hwint), 32'd0);
        bus("pend_rd2", 1'b0, 1'b1, 32'h7FF0, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h2);
        dev_irq = 4'b0001;
        bus("coincide", 1'b1, 1'b0, 32'h7FF0, 32'h3, 4'b0000, 1'b0, 1'b0, 32'h0);
        check("coincide.hwint", 32'(hwint), 32'b000001);
        bus("pend_rd3", 1'b0, 1'b1, 32'h7FF0, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h1);

        // Load PEND=0xF, MASK=0xF, then reset in the middle of a read
        dev_irq = 4'b0000;
        tick();
        dev_irq = 4'b1111;
        tick();
        bus("mask_all", 1'b1, 1'b0, 32'h7FF4, 32'hF, 4'b0000, 1'b0, 1'b0, 32'h0);
        check("all.hwint", 32'(hwint), 32'b001111);
        ren = 1'b1; praddr = 32'h7FF0;
        tick();
        check("abort.in_resp", 32'(pr_ready), 32'd1);
        reset = 1'b1;
        ren = 1'b0;
        #1;
        check("abort.prrd", prrd, 32'd0);
        check("abort.rdy", 32'(pr_ready), 32'd0);
        check("abort.err", 32'(pr_err), 32'd0);
        check("abort.hwint", 32'(hwint), 32'd0);
        check("abort.we", 32'(dev_we), 32'd0);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst.rdy", 32'(pr_ready), 32'd0);
        end
        bus("post_rst.mask", 1'b1, 1'b0, 32'h7FF4, 32'hF, 4'b0000, 1'b0, 1'b0, 32'h0);
        check("post_rst.hwint", 32'(hwint), 32'd0);
        bus("post_rst.pend", 1'b0, 1'b1, 32'h7FF0, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
        dev_irq = 4'b1110;
        tick();
        dev_irq = 4'b1111;
        tick();
        check("re_edge.hwint", 32'(hwint), 32'b000001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
